calc_core: RTL and testbench
============================

Name: calc_core

Overview:
- Parametrised successor to the fixed 16-bit keypad calculator.
- Accepts one keypress per `newkey` pulse and performs hex digit entry, backspace and clear.
- Supports chained binary operations (ADD, SUB, MUL, AND, OR, XOR), plus equals with repeat-last-operation.
- Multiply is a multi-cycle shift-add sequencer with a busy indication. Overflow is sticky. The block drives the display value directly.

Parameters:
- WIDTH, 16, datapath width in bits; multiple of 4, minimum 8.
- MUL_EN, 1, 1 = MUL key supported; 0 = MUL key ignored (no busy, no `key_dropped`).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- newkey  in  1  high for exactly one cycle per keypress
- keycode  in  5  key sampled when `newkey`=1
- display  out  WIDTH  value to show (entry or accumulator)
- pending_op  out  3  latched operator: 0 none, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR
- busy  out  1  multiply in progress
- overflow  out  1  sticky arithmetic overflow flag
- key_dropped  out  1  one-cycle pulse when a key is discarded because `busy`=1

Behaviour:
- Keycodes:
  - 0x00-0x0F: hex digit.
  - 0x10 ADD, 0x11 SUB, 0x12 MUL, 0x13 AND, 0x14 OR, 0x15 XOR.
  - 0x16 EQ, 0x17 CLR, 0x18 BKSP.
  - 0x19-0x1F: ignored (no state change, no `key_dropped`).
- Reset:
  - `display`=0, `pending_op`=0, `busy`=0, `overflow`=0, `key_dropped`=0.
  - Internal `entry`, `acc`, `last_operand`, `last_op` = 0; `fresh`=1; FSM = IDLE.
  - Reset mid-multiply aborts immediately.
- FSM states:
  - IDLE: entry/compute.
  - MUL: shift-add iteration.
  - IDLE is re-entered when the multiply finishes.
- Digit (IDLE):
  - If `fresh`: `entry`=digit, `fresh`=0.
  - Else if `entry[WIDTH-1:WIDTH-4]`≠0: digit ignored (entry full, no wrap).
  - Else `entry`={`entry`[WIDTH-5:0],digit}.
  - `display`=`entry` next cycle.
- BKSP: `entry`=`entry`>>4; `display`=`entry`. No effect if `fresh`.
- Operator key X (IDLE):
  - If `pending_op`=0: `acc`=`entry`.
  - Else: `acc`=`acc` `pending_op` `entry`.
  - Then `pending_op`=X, `fresh`=1, `display`=`acc`.
  - Two consecutive operator keys (`fresh`=1): only `pending_op` is replaced; no computation.
- EQ:
  - If `pending_op`≠0: `last_operand`=`entry`, `last_op`=`pending_op`, `acc`=`acc` op `entry`, `pending_op`=0.
  - Else if `last_op`≠0 (repeat): `acc`=`acc` `last_op` `last_operand`.
  - Else: `acc`=`entry`.
  - `fresh`=1; `display`=`acc`.
- Digit after EQ: starts a new entry. The following operator key uses `acc`=`entry` because `pending_op`=0.
- CLR: same state as reset (all outputs and internals zero, `fresh`=1). Accepted even when `busy`, where it aborts the multiply.
- Latency: ADD/SUB/AND/OR/XOR results appear on `display` the cycle after the `newkey` cycle.
- Arithmetic:
  - Results are truncated to WIDTH.
  - ADD carry-out sets `overflow`.
  - SUB borrow (`acc`<`entry`, unsigned) sets `overflow`.
  - Logic ops never set `overflow`.
  - `overflow` clears only on CLR or reset.
- MUL:
  - The triggering key (operator or EQ) moves the FSM to MUL; `busy`=1 from the next cycle.
  - Exactly WIDTH iteration cycles, one multiplier bit per cycle, into a 2·WIDTH product.
  - After the last iteration: `acc`=product[WIDTH-1:0]; `overflow` set if product[2·WIDTH-1:WIDTH]≠0; `busy`=0; `display`=`acc`.
  - Any pending `pending_op`/`fresh` updates for the triggering key are committed with the result.
  - `display` holds its previous value while busy.
- Keys while `busy` (except CLR): discarded; `key_dropped`=1 for the following cycle.
- `newkey` pulses are assumed non-overlapping by protocol; back-to-back pulses in consecutive cycles must both be processed when IDLE.

Test Plan (WIDTH=16):
- Digits 1,2,3,4,5 → `display` 0x0001, 0x0012, 0x0123, 0x1234, 0x1234 (fifth ignored); BKSP → 0x0123.
- 0xFFF0 ADD 0x0020 EQ → `display`=0x0010, `overflow`=1; CLR → `display`=0, `overflow`=0.
- 3 SUB 5 EQ → 0xFFFE, `overflow`=1; then EQ again → 0xFFF9 (repeat SUB 5).
- 0x0100 MUL 0x0300 EQ → `busy` high exactly 16 cycles, then `display`=0x0000, `overflow`=1. Repeat with 0x0012 MUL 0x0034 → 0x03A8, `overflow`=0.
- During a multiply send digit 7 → `key_dropped` pulses once, result unchanged. Send CLR mid-multiply → `busy`=0 next cycle, `display`=0.
- Chain 0xF0 AND 0x3C OR 0x01 XOR 0xFF EQ → intermediate `display` 0x0030, 0x0031; final 0x00CE. Assert reset mid-entry → all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/calc_core.sv
// Keypad calculator core: hex entry, chained binary ops, repeat-equals and a
// shift-add multiply sequencer. Display, operator and flags are all registered.
module calc_core #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             newkey,
    input  logic [4:0]       keycode,
    output logic [WIDTH-1:0] display,
    output logic [2:0]       pending_op,
    output logic             busy,
    output logic             overflow,
    output logic             key_dropped
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [4:0] K_EQ    = 5'h16;
    localparam logic [4:0] K_CLR   = 5'h17;
    localparam logic [4:0] K_BKSP  = 5'h18;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    // Bit WIDTH of the result is the carry (ADD) or borrow (SUB) flag.
    function automatic logic [WIDTH:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = {1'b0, a};
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    state_t             state;
    logic [WIDTH-1:0]   entry, acc, last_operand, mplier;
    logic [2:0]         last_op, commit_op;
    logic               fresh;
    logic [2*WIDTH-1:0] mcand, prod, prod_next;
    logic [CW-1:0]      cnt;

    logic               is_digit, is_op, op_ok;
    logic [2:0]         key_op, next_op, exec_op;
    logic [WIDTH-1:0]   exec_b, digit_val, shifted_entry;
    logic [WIDTH:0]     alu_res;

    always_comb begin
        is_digit      = (keycode[4] == 1'b0);
        is_op         = (keycode >= 5'h10) && (keycode <= 5'h15);
        key_op        = keycode[2:0] + 3'd1;
        op_ok         = is_op && ((key_op != OP_MUL) || (MUL_EN != 0));
        next_op       = is_op ? key_op : OP_NONE;
        digit_val     = {{(WIDTH-4){1'b0}}, keycode[3:0]};
        shifted_entry = {entry[WIDTH-5:0], keycode[3:0]};
        // EQ with no operator pending replays the last operation
        if (keycode == K_EQ && pending_op == OP_NONE) begin
            exec_op = last_op;
            exec_b  = last_operand;
        end else begin
            exec_op = pending_op;
            exec_b  = entry;
        end
        alu_res   = alu(exec_op, acc, exec_b);
        prod_next = prod + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            entry        <= '0;
            acc          <= '0;
            last_operand <= '0;
            last_op      <= OP_NONE;
            commit_op    <= OP_NONE;
            fresh        <= 1'b1;
            mcand        <= '0;
            mplier       <= '0;
            prod         <= '0;
            cnt          <= '0;
            display      <= '0;
            pending_op   <= OP_NONE;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            key_dropped  <= 1'b0;
        end else if (newkey && keycode == K_CLR) begin
            state        <= S_IDLE;
            entry        <= '0;
            acc          <= '0;
            last_operand <= '0;
            last_op      <= OP_NONE;
            commit_op    <= OP_NONE;
            fresh        <= 1'b1;
            mcand        <= '0;
            mplier       <= '0;
            prod         <= '0;
            cnt          <= '0;
            display      <= '0;
            pending_op   <= OP_NONE;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            key_dropped  <= 1'b0;
        end else begin
            key_dropped <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (newkey) begin
                        if (is_digit) begin
                            if (fresh) begin
                                entry   <= digit_val;
                                display <= digit_val;
                                fresh   <= 1'b0;
                            end else if (entry[WIDTH-1 -: 4] == 4'h0) begin
                                entry   <= shifted_entry;
                                display <= shifted_entry;
                            end
                        end else if (keycode == K_BKSP) begin
                            if (!fresh) begin
                                entry   <= entry >> 4;
                                display <= entry >> 4;
                            end
                        end else if (op_ok && fresh) begin
                            pending_op <= key_op;
                        end else if (op_ok || keycode == K_EQ) begin
                            if (keycode == K_EQ && pending_op != OP_NONE) begin
                                last_operand <= entry;
                                last_op      <= pending_op;
                            end
                            if (exec_op == OP_NONE) begin
                                acc        <= entry;
                                display    <= entry;
                                pending_op <= next_op;
                                fresh      <= 1'b1;
                            end else if (exec_op == OP_MUL) begin
                                mcand     <= {{WIDTH{1'b0}}, acc};
                                mplier    <= exec_b;
                                prod      <= '0;
                                cnt       <= '0;
                                commit_op <= next_op;
                                busy      <= 1'b1;
                                state     <= S_MUL;
                            end else begin
                                acc        <= alu_res[WIDTH-1:0];
                                display    <= alu_res[WIDTH-1:0];
                                overflow   <= overflow | alu_res[WIDTH];
                                pending_op <= next_op;
                                fresh      <= 1'b1;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (newkey && keycode <= K_BKSP)
                        key_dropped <= 1'b1;
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        acc        <= prod_next[WIDTH-1:0];
                        display    <= prod_next[WIDTH-1:0];
                        overflow   <= overflow | (|prod_next[2*WIDTH-1:WIDTH]);
                        pending_op <= commit_op;
                        fresh      <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core (WIDTH=16): stimulus queues expected outputs,
// a negedge monitor pops and compares whenever the core presents a result.
module tb_calc_core;
    localparam int W = 16;
    localparam logic [4:0] K_ADD = 5'h10, K_SUB = 5'h11, K_MUL = 5'h12, K_AND = 5'h13;
    localparam logic [4:0] K_OR = 5'h14, K_XOR = 5'h15, K_EQ = 5'h16, K_CLR = 5'h17;
    localparam logic [4:0] K_BKSP = 5'h18;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         newkey = 1'b0;
    logic [4:0]   keycode = 5'h0;
    logic [W-1:0] display;
    logic [2:0]   pending_op;
    logic         busy, overflow, key_dropped;

    calc_core #(.WIDTH(W), .MUL_EN(1)) dut (
        .clock(clock), .reset(reset), .newkey(newkey), .keycode(keycode),
        .display(display), .pending_op(pending_op), .busy(busy),
        .overflow(overflow), .key_dropped(key_dropped)
    );

    always #5 clock = ~clock;

    typedef struct {
        string        tag;
        logic [W-1:0] disp;
        logic [2:0]   pop;
        logic         ovf;
        logic         kd;
        int           bcyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] d, input logic [2:0] p,
                              input logic o, input logic kd, input int bcyc);
        exp_t e;
        e.tag = tag; e.disp = d; e.pop = p; e.ovf = o; e.kd = kd; e.bcyc = bcyc;
        q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] c);
        @(posedge clock); #1;
        newkey = 1'b1; keycode = c;
        @(posedge clock); #1;
        newkey = 1'b0;
    endtask

    task automatic drive2(input logic [4:0] c1, input logic [4:0] c2);
        @(posedge clock); #1;
        newkey = 1'b1; keycode = c1;
        @(posedge clock); #1;
        keycode = c2;
        @(posedge clock); #1;
        newkey = 1'b0;
    endtask

    task automatic key(input logic [4:0] c, input logic [W-1:0] d, input logic [2:0] p,
                       input logic o, input string tag);
        expect_out(tag, d, p, o, 1'b0, 0);
        drive(c);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 100) begin
            @(posedge clock); #1;
            i++;
        end
        chk("mul_done", {31'b0, busy}, 32'd0);
    endtask

    // Monitor: a result is presented after an idle keypress, when busy falls,
    // or when key_dropped pulses.
    logic pend = 1'b0;
    logic prev_busy = 1'b0;
    int   bcnt = 0;
    initial forever begin
        @(negedge clock);
        if (reset) begin
            pend = 1'b0; prev_busy = 1'b0; bcnt = 0;
        end else begin
            if (key_dropped || (prev_busy && !busy) || (pend && !busy)) begin
                if (q.size() == 0) begin
                    chk("spurious_output", q.size(), 32'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.tag, "_disp"}, {16'b0, display}, {16'b0, e.disp});
                    chk({e.tag, "_pop"}, {29'b0, pending_op}, {29'b0, e.pop});
                    chk({e.tag, "_ovf"}, {31'b0, overflow}, {31'b0, e.ovf});
                    chk({e.tag, "_kd"}, {31'b0, key_dropped}, {31'b0, e.kd});
                    if (e.bcyc > 0) chk({e.tag, "_busycyc"}, bcnt, e.bcyc);
                end
                if (!busy) bcnt = 0;
            end
            if (busy) bcnt++;
            pend = newkey && !busy;
            prev_busy = busy;
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_disp", {16'b0, display}, 32'd0);
        chk("rst_pop", {29'b0, pending_op}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_kd", {31'b0, key_dropped}, 32'd0);
        reset = 1'b0;

        // digit entry, full entry, backspace, ignored code
        key(5'h1, 16'h0001, 3'd0, 1'b0, "d1");
        key(5'h2, 16'h0012, 3'd0, 1'b0, "d2");
        key(5'h3, 16'h0123, 3'd0, 1'b0, "d3");
        key(5'h4, 16'h1234, 3'd0, 1'b0, "d4");
        key(5'h5, 16'h1234, 3'd0, 1'b0, "d5_full");
        key(K_BKSP, 16'h0123, 3'd0, 1'b0, "bksp");
        key(5'h1A, 16'h0123, 3'd0, 1'b0, "ignored");
        key(K_CLR, 16'h0000, 3'd0, 1'b0, "clr1");

        // ADD with carry-out
        key(5'hF, 16'h000F, 3'd0, 1'b0, "a1");
        key(5'hF, 16'h00FF, 3'd0, 1'b0, "a2");
        key(5'hF, 16'h0FFF, 3'd0, 1'b0, "a3");
        key(5'h0, 16'hFFF0, 3'd0, 1'b0, "a4");
        key(K_ADD, 16'hFFF0, 3'd1, 1'b0, "add");
        key(5'h2, 16'h0002, 3'd1, 1'b0, "a5");
        key(5'h0, 16'h0020, 3'd1, 1'b0, "a6");
        key(K_EQ, 16'h0010, 3'd0, 1'b1, "add_ovf");
        key(K_CLR, 16'h0000, 3'd0, 1'b0, "clr_ovf");

        // SUB with borrow, then repeat-equals
        key(5'h3, 16'h0003, 3'd0, 1'b0, "s1");
        key(K_SUB, 16'h0003, 3'd2, 1'b0, "sub");
        key(5'h5, 16'h0005, 3'd2, 1'b0, "s2");
        key(K_EQ, 16'hFFFE, 3'd0, 1'b1, "sub_borrow");
        key(K_EQ, 16'hFFF9, 3'd0, 1'b1, "rep_sub");
        key(K_CLR, 16'h0000, 3'd0, 1'b0, "clr2");

        // MUL overflowing, then MUL in range
        key(5'h1, 16'h0001, 3'd0, 1'b0, "m1");
        key(5'h0, 16'h0010, 3'd0, 1'b0, "m2");
        key(5'h0, 16'h0100, 3'd0, 1'b0, "m3");
        key(K_MUL, 16'h0100, 3'd3, 1'b0, "mul");
        key(5'h3, 16'h0003, 3'd3, 1'b0, "m4");
        key(5'h0, 16'h0030, 3'd3, 1'b0, "m5");
        key(5'h0, 16'h0300, 3'd3, 1'b0, "m6");
        expect_out("mul_ovf", 16'h0000, 3'd0, 1'b1, 1'b0, 16);
        drive(K_EQ);
        wait_idle();
        key(K_CLR, 16'h0000, 3'd0, 1'b0, "clr3");
        key(5'h1, 16'h0001, 3'd0, 1'b0, "n1");
        key(5'h2, 16'h0012, 3'd0, 1'b0, "n2");
        key(K_MUL, 16'h0012, 3'd3, 1'b0, "mul2op");
        key(5'h3, 16'h0003, 3'd3, 1'b0, "n3");
        key(5'h4, 16'h0034, 3'd3, 1'b0, "n4");
        expect_out("mul_ok", 16'h03A8, 3'd0, 1'b0, 1'b0, 16);
        drive(K_EQ);
        wait_idle();

        // repeat MUL (0x3A8*0x34) with a key dropped mid-multiply
        drive(K_EQ);
        repeat (2) @(posedge clock);
        expect_out("drop", 16'h03A8, 3'd0, 1'b0, 1'b1, 0);
        drive(5'h7);
        expect_out("mul_rep", 16'hBE20, 3'd0, 1'b0, 1'b0, 16);
        wait_idle();

        // CLR aborts a multiply in progress
        drive(K_EQ);
        repeat (5) @(posedge clock);
        expect_out("clr_abort", 16'h0000, 3'd0, 1'b0, 1'b0, 7);
        drive(K_CLR);
        chk("abort_busy", {31'b0, busy}, 32'd0);

        // logic-op chain with back-to-back keypresses
        key(5'hF, 16'h000F, 3'd0, 1'b0, "c1");
        key(5'h0, 16'h00F0, 3'd0, 1'b0, "c2");
        key(K_AND, 16'h00F0, 3'd4, 1'b0, "and");
        expect_out("bb3", 16'h0003, 3'd4, 1'b0, 1'b0, 0);
        expect_out("bbC", 16'h003C, 3'd4, 1'b0, 1'b0, 0);
        drive2(5'h3, 5'hC);
        key(K_OR, 16'h0030, 3'd5, 1'b0, "or");
        key(5'h0, 16'h0000, 3'd5, 1'b0, "c3");
        key(5'h1, 16'h0001, 3'd5, 1'b0, "c4");
        key(K_XOR, 16'h0031, 3'd6, 1'b0, "xor");
        key(5'hF, 16'h000F, 3'd6, 1'b0, "c5");
        key(5'hF, 16'h00FF, 3'd6, 1'b0, "c6");
        key(K_EQ, 16'h00CE, 3'd0, 1'b0, "chain");

        // new entry after EQ, operator replacement, async reset mid-entry
        key(5'h1, 16'h0001, 3'd0, 1'b0, "r1");
        key(5'h2, 16'h0012, 3'd0, 1'b0, "r2");
        key(K_ADD, 16'h0012, 3'd1, 1'b0, "r_add");
        key(K_SUB, 16'h0012, 3'd2, 1'b0, "op_replace");
        key(5'h3, 16'h0003, 3'd2, 1'b0, "r3");
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_disp", {16'b0, display}, 32'd0);
        chk("arst_pop", {29'b0, pending_op}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_ovf", {31'b0, overflow}, 32'd0);
        chk("arst_kd", {31'b0, key_dropped}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        chk("queue_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
